// File: rtl/uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_receiver
// Brief    : One-sample-per-bit UART receiver (8N1+) feeding a FWFT receive
//            FIFO, with framing-error pulse and sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module uart_receiver #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk_115200hz,
  input  logic       reset,
  input  logic       rx,
  output logic [0:7] rd_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       clr_err,
  output logic       busy
);

  localparam int            c_AW      = $clog2(FIFO_DEPTH);
  localparam logic [c_AW:0] c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_WAIT_IDLE = 2'd0,
    S_IDLE      = 2'd1,
    S_DATA      = 2'd2,
    S_STOP      = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // rx synchroniser; resets to the idle (high) line level
  // --------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_sync;

  always_ff @(posedge clk_115200hz or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
    end
  end

  assign rx_sync = sync_q[SYNC_STAGES-1];

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  state_t     state_q,     state_d;
  logic [2:0] bit_idx_q,   bit_idx_d;
  logic [0:7] shift_q,     shift_d;
  logic       frame_err_q, frame_err_d;
  logic       push;

  always_ff @(posedge clk_115200hz or posedge reset) begin
    if (reset) begin
      state_q     <= S_WAIT_IDLE;
      bit_idx_q   <= 3'd7;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    case (state_q)
      S_WAIT_IDLE: begin
        if (rx_sync) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (!rx_sync) begin
          state_d   = S_DATA;
          bit_idx_d = 3'd7;
        end
      end
      S_DATA: begin
        // First serial data bit lands in index 7, last in index 0
        shift_d[bit_idx_q] = rx_sync;
        if (bit_idx_q == 3'd0) begin
          state_d = S_STOP;
        end else begin
          bit_idx_d = bit_idx_q - 3'd1;
        end
      end
      S_STOP: begin
        if (rx_sync) begin
          push    = 1'b1;
          state_d = S_IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = S_WAIT_IDLE;
        end
      end
      default: state_d = S_WAIT_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Receive FIFO (first-word fall-through)
  // --------------------------------------------------------------------------
  logic [c_AW:0] wr_ptr_q;
  logic [c_AW:0] rd_ptr_q;
  logic [0:7]    mem_q [FIFO_DEPTH];
  logic          overrun_q;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push_ok;
  logic          drop;

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[c_AW] != rd_ptr_q[c_AW]) &&
                      (wr_ptr_q[c_AW-1:0] == rd_ptr_q[c_AW-1:0]);
  assign pop        = !fifo_empty && rd_ready;
  // A pop on the same edge frees the slot the push writes into
  assign push_ok    = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;

  always_ff @(posedge clk_115200hz or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      overrun_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q[c_AW-1:0]] <= shift_q;
        wr_ptr_q                  <= wr_ptr_q + c_PTR_ONE;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
      end
      overrun_q <= drop || (overrun_q && !clr_err);
    end
  end

  assign rd_data   = mem_q[rd_ptr_q[c_AW-1:0]];
  assign rd_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
  assign busy      = (state_q == S_DATA) || (state_q == S_STOP);

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_receiver
// Brief    : Self-checking bench for uart_receiver against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_receiver;

  localparam int SYNC  = 2;
  localparam int DEPTH = 4;
  localparam int LAT   = SYNC + 9;

  logic       clk_115200hz = 1'b0;
  logic       reset        = 1'b1;
  logic       rx           = 1'b1;
  logic       rd_ready     = 1'b0;
  logic       clr_err      = 1'b0;
  logic [0:7] rd_data;
  logic       rd_valid;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         checks = 0;
  int         errors = 0;
  int         fe_cnt = 0;
  int         valid_seen = 0;
  logic [7:0] got_q[$];

  uart_receiver #(
    .SYNC_STAGES(SYNC),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_115200hz(clk_115200hz),
    .reset       (reset),
    .rx          (rx),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_ready    (rd_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .clr_err     (clr_err),
    .busy        (busy)
  );

  always #5 clk_115200hz = ~clk_115200hz;

  // Serial order of one frame: bit 0 start, bits 1..8 data LSB first, bit 9 stop
  function automatic logic [9:0] frame_of(input logic [7:0] d, input logic stop);
    return {stop, d, 1'b0};
  endfunction

  // One bit period: drive, capture any accepted byte, advance past the edge
  task automatic step(input logic b, input logic rdy);
    rx       = b;
    rd_ready = rdy;
    #1;
    if (rd_valid && rd_ready) got_q.push_back(rd_data);
    @(posedge clk_115200hz);
    #1;
    if (frame_err) fe_cnt++;
    if (rd_valid)  valid_seen++;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int pct, input int idle);
    logic [9:0] f;
    f = frame_of(d, stop);
    for (int j = 0; j < 10 + idle; j++) begin
      step((j < 10) ? f[j] : 1'b1, $urandom_range(0, 99) < pct);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(posedge clk_115200hz);
    #1;
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid got %b expected 0", rd_valid); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data got %h expected 00", rd_data); end
    checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b expected 0", frame_err); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b expected 0", overrun); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", busy); end
    reset = 1'b0;
    repeat (4) step(1'b1, 1'b0);
  endtask

  task automatic test_single_frame();
    bit         bits[10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic [7:0] exp;
    int         first = -1;
    int         bcnt  = 0;
    exp = '0;
    for (int i = 0; i < 8; i++) exp[i] = bits[1 + i];
    got_q.delete();
    for (int i = 0; i < 16; i++) begin
      step((i < 10) ? bits[i] : 1'b1, 1'b0);
      if (busy) bcnt++;
      if (rd_valid && first < 0) first = i;
    end
    checks++; if (first !== LAT) begin errors++; $display("FAIL single_latency got %0d expected %0d", first, LAT); end
    checks++; if (bcnt !== 9) begin errors++; $display("FAIL single_busy_cycles got %0d expected 9", bcnt); end
    checks++; if (rd_data !== exp) begin errors++; $display("FAIL single_rd_data got %h expected %h", rd_data, exp); end
    step(1'b1, 1'b1);
    checks++; if (got_q.size() !== 1 || got_q[0] !== exp) begin errors++; $display("FAIL single_pop got %0d bytes expected 1 of %h", got_q.size(), exp); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL single_empty_after_pop got %b expected 0", rd_valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat[5] = '{8'h00, 8'hFF, 8'hA5, 8'h3C, 8'h77};
    logic [7:0] model_q[$];
    logic       ovr_exp = 1'b0;
    got_q.delete();
    fe_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      send_frame(pat[i], 1'b1, 0, 0);
      if (model_q.size() < DEPTH) model_q.push_back(pat[i]); else ovr_exp = 1'b1;
    end
    repeat (3) step(1'b1, 1'b0);
    checks++; if (overrun !== ovr_exp) begin errors++; $display("FAIL b2b_no_overrun got %b expected %b", overrun, ovr_exp); end
    checks++; if (rd_data !== model_q[0]) begin errors++; $display("FAIL b2b_head got %h expected %h", rd_data, model_q[0]); end
    send_frame(pat[4], 1'b1, 0, 3);
    if (model_q.size() < DEPTH) model_q.push_back(pat[4]); else ovr_exp = 1'b1;
    checks++; if (overrun !== ovr_exp) begin errors++; $display("FAIL b2b_overrun got %b expected %b", overrun, ovr_exp); end
    repeat (8) step(1'b1, 1'b1);
    checks++; if (got_q.size() !== model_q.size()) begin errors++; $display("FAIL b2b_count got %0d expected %0d", got_q.size(), model_q.size()); end
    for (int i = 0; i < model_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== model_q[i]) begin errors++; $display("FAIL b2b_byte%0d got %h expected %h", i, got_q[i], model_q[i]); end
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun_sticky got %b expected 1", overrun); end
    checks++; if (fe_cnt !== 0) begin errors++; $display("FAIL b2b_frame_err got %0d expected 0", fe_cnt); end
    clr_err = 1'b1;
    step(1'b1, 1'b0);
    clr_err = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_clr_err got %b expected 0", overrun); end
  endtask

  task automatic test_frame_error();
    got_q.delete();
    fe_cnt     = 0;
    valid_seen = 0;
    send_frame(8'h96, 1'b0, 0, 0);
    repeat (5) step(1'b0, 1'b0);
    repeat (4) step(1'b1, 1'b0);
    checks++; if (fe_cnt !== 1) begin errors++; $display("FAIL ferr_pulses got %0d expected 1", fe_cnt); end
    checks++; if (valid_seen !== 0) begin errors++; $display("FAIL ferr_no_push got %0d valid cycles expected 0", valid_seen); end
    send_frame(8'h5A, 1'b1, 0, 3);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin errors++; $display("FAIL ferr_recover got v=%b %h expected v=1 5a", rd_valid, rd_data); end
    step(1'b1, 1'b1);
    checks++; if (got_q.size() !== 1 || fe_cnt !== 1) begin errors++; $display("FAIL ferr_recover_pop got %0d bytes %0d errs expected 1 1", got_q.size(), fe_cnt); end
  endtask

  task automatic test_full_pop_on_stop();
    logic [7:0] model_q[$];
    logic [7:0] nb;
    logic [9:0] f;
    got_q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      nb = 8'($urandom);
      send_frame(nb, 1'b1, 0, 0);
      model_q.push_back(nb);
    end
    repeat (3) step(1'b1, 1'b0);
    nb = 8'($urandom);
    f  = frame_of(nb, 1'b1);
    // Ready only on the edge that samples the stop bit: pop and push coincide
    for (int j = 0; j < LAT + 3; j++) begin
      step((j < 10) ? f[j] : 1'b1, j == LAT);
    end
    model_q.push_back(nb);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL fullpop_overrun got %b expected 0", overrun); end
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL fullpop_one_pop got %0d expected 1", got_q.size()); end
    repeat (10) step(1'b1, 1'b1);
    checks++; if (got_q.size() !== model_q.size()) begin errors++; $display("FAIL fullpop_count got %0d expected %0d", got_q.size(), model_q.size()); end
    for (int i = 0; i < model_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== model_q[i]) begin errors++; $display("FAIL fullpop_byte%0d got %h expected %h", i, got_q[i], model_q[i]); end
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] f;
    got_q.delete();
    send_frame(8'h11, 1'b1, 0, 3);
    f = frame_of(8'h00, 1'b1);
    for (int j = 0; j < 5; j++) step(f[j], 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got %b expected 1", busy); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (rd_valid !== 1'b0 || busy !== 1'b0 || rd_data !== 8'h00) begin errors++; $display("FAIL rst_mid_async got v=%b busy=%b %h expected 0 0 00", rd_valid, busy, rd_data); end
    repeat (2) @(posedge clk_115200hz);
    #1;
    reset      = 1'b0;
    valid_seen = 0;
    repeat (20) step(1'b0, 1'b0);
    checks++; if (valid_seen !== 0) begin errors++; $display("FAIL rst_mid_no_push got %0d valid cycles expected 0", valid_seen); end
    repeat (4) step(1'b1, 1'b0);
    send_frame(8'hC3, 1'b1, 0, 3);
    checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hC3) begin errors++; $display("FAIL rst_mid_recover got v=%b %h expected v=1 c3", rd_valid, rd_data); end
    step(1'b1, 1'b1);
    checks++; if (got_q.size() !== 1) begin errors++; $display("FAIL rst_mid_count got %0d expected 1", got_q.size()); end
  endtask

  task automatic test_loopback();
    logic [7:0] exp_q[$];
    logic [7:0] b;
    got_q.delete();
    fe_cnt = 0;
    for (int n = 0; n < 256; n++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1, 50, $urandom_range(0, 2));
    end
    repeat (20) step(1'b1, 1'b1);
    checks++; if (got_q.size() !== exp_q.size()) begin errors++; $display("FAIL loop_count got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) begin errors++; $display("FAIL loop_byte%0d got %h expected %h", i, got_q[i], exp_q[i]); end
    end
    checks++; if (fe_cnt !== 0 || overrun !== 1'b0) begin errors++; $display("FAIL loop_flags got ferr=%0d ovr=%b expected 0 0", fe_cnt, overrun); end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_frame_error();
    test_full_pop_on_stop();
    test_reset_mid_frame();
    test_loopback();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
